// File: rtl/nerv_wb_bridge_pkg.sv
// Shared types and constants for the nerv core to Wishbone bridge.
package nerv_wb_bridge_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bridge_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
  } wb_req_t;

  // A request with no byte strobes is a read.
  function automatic wb_req_t make_req(input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       input logic [3:0]  wstrb);
    wb_req_t req;
    req.addr  = addr;
    req.wdata = wdata;
    req.wstrb = wstrb;
    req.we    = |wstrb;
    return req;
  endfunction

endpackage

// File: rtl/nerv_wb_channel.sv
// One Wishbone channel of the bridge: request register, strobe/done tracking
// and read-data latch.
module nerv_wb_channel
  import nerv_wb_bridge_pkg::*;
#(
  parameter logic [31:0] RESET_RDATA   = 32'h0000_0000,
  parameter logic [31:0] TIMEOUT_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        launch,
  input  wb_req_t     req_in,
  input  logic        ack,
  input  logic [31:0] rdata_in,
  input  logic        force_done,
  output logic        done,
  output logic        cyc,
  output logic        stb,
  output wb_req_t     req,
  output logic [31:0] rdata
);

  wb_req_t     req_r;
  logic        stb_r;
  logic        done_r;
  logic [31:0] rdata_r;

  // Request capture, strobe lifetime and read-data latch; an ack beats a forced completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r   <= '0;
      stb_r   <= 1'b0;
      done_r  <= 1'b1;
      rdata_r <= RESET_RDATA;
    end else if (launch) begin
      req_r   <= req_in;
      stb_r   <= 1'b1;
      done_r  <= 1'b0;
    end else if (stb_r && ack) begin
      stb_r  <= 1'b0;
      done_r <= 1'b1;
      if (!req_r.we) begin
        rdata_r <= rdata_in;
      end
    end else if (stb_r && force_done) begin
      stb_r  <= 1'b0;
      done_r <= 1'b1;
      if (!req_r.we) begin
        rdata_r <= TIMEOUT_RDATA;
      end
    end
  end

  // Done means "no longer outstanding after this edge", so same-cycle acks end BUSY.
  assign done  = done_r | (stb_r & (ack | force_done));
  assign cyc   = stb_r;
  assign stb   = stb_r;
  assign req   = req_r;
  assign rdata = rdata_r;

endmodule

// File: rtl/nerv_wb_bridge.sv
// Ack-driven bridge from the nerv fixed-latency memory ports to the
// instruction and data Wishbone buses. Optional ack timeout: WB_TIMEOUT_EN.
module nerv_wb_bridge
  import nerv_wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] RESET_INSTR    = NOP_INSTR,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  input  logic        dmem_valid_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [3:0]  dmem_wstrb_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_o,
  output logic        stall_o,
  output logic        core_cyc_o,
  output logic        core_stb_o,
  output logic        core_we_o,
  output logic [3:0]  core_wstrb_o,
  output logic [31:0] core_addr_o,
  output logic [31:0] core_data_o,
  input  logic [31:0] core_data_i,
  input  logic        core_ack_i,
  output logic        data_mem_cyc_o,
  output logic        data_mem_stb_o,
  output logic        data_mem_we_o,
  output logic [3:0]  data_mem_wstrb_o,
  output logic [31:0] data_mem_addr_o,
  output logic [31:0] data_mem_data_o,
  input  logic [31:0] data_mem_data_i,
  input  logic        data_mem_ack_i,
  output logic        err_o
);

  bridge_state_t state_r;
  bridge_state_t state_next_s;
  logic          launch_i_s;
  logic          launch_d_s;
  logic          i_done_s;
  logic          d_done_s;
  logic          force_done_s;
  wb_req_t       i_req_s;
  wb_req_t       d_req_s;

  // Bridge state register.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Launch every request from IDLE; leave BUSY once both channels have finished.
  always_comb begin
    state_next_s = state_r;
    launch_i_s   = 1'b0;
    launch_d_s   = 1'b0;
    case (state_r)
      IDLE: begin
        launch_i_s   = 1'b1;
        launch_d_s   = dmem_valid_i;
        state_next_s = BUSY;
      end
      BUSY: begin
        if (i_done_s && d_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = BUSY;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt_r;
  logic        err_r;

  // Cycles spent in the current BUSY period.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      wait_cnt_r <= 16'd0;
    end else if (state_r == IDLE) begin
      wait_cnt_r <= 16'd0;
    end else begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end
  end

  assign force_done_s = (state_r == BUSY) && (wait_cnt_r == TIMEOUT_LAST);

  // Sticky error: set only if some channel was still unacked when forced.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      err_r <= 1'b0;
    end else if (force_done_s && ((core_stb_o && !core_ack_i) ||
                                  (data_mem_stb_o && !data_mem_ack_i))) begin
      err_r <= 1'b1;
    end
  end

  assign err_o = err_r;
`else
  assign force_done_s = 1'b0;
  assign err_o        = 1'b0;
`endif

  nerv_wb_channel #(
    .RESET_RDATA   (RESET_INSTR),
    .TIMEOUT_RDATA (TIMEOUT_RDATA)
  ) u_ichan (
    .clk        (clk_core),
    .rst        (rst_core),
    .launch     (launch_i_s),
    .req_in     (make_req(imem_addr_i, 32'h0000_0000, 4'h0)),
    .ack        (core_ack_i),
    .rdata_in   (core_data_i),
    .force_done (force_done_s),
    .done       (i_done_s),
    .cyc        (core_cyc_o),
    .stb        (core_stb_o),
    .req        (i_req_s),
    .rdata      (imem_data_o)
  );

  nerv_wb_channel #(
    .RESET_RDATA   (32'h0000_0000),
    .TIMEOUT_RDATA (TIMEOUT_RDATA)
  ) u_dchan (
    .clk        (clk_core),
    .rst        (rst_core),
    .launch     (launch_d_s),
    .req_in     (make_req(dmem_addr_i, dmem_wdata_i, dmem_wstrb_i)),
    .ack        (data_mem_ack_i),
    .rdata_in   (data_mem_data_i),
    .force_done (force_done_s),
    .done       (d_done_s),
    .cyc        (data_mem_cyc_o),
    .stb        (data_mem_stb_o),
    .req        (d_req_s),
    .rdata      (dmem_rdata_o)
  );

  // The instruction channel is built with zero write fields, so these stay 0.
  assign core_addr_o      = i_req_s.addr;
  assign core_we_o        = i_req_s.we;
  assign core_wstrb_o     = i_req_s.wstrb;
  assign core_data_o      = i_req_s.wdata;
  assign data_mem_addr_o  = d_req_s.addr;
  assign data_mem_we_o    = d_req_s.we;
  assign data_mem_wstrb_o = d_req_s.wstrb;
  assign data_mem_data_o  = d_req_s.wdata;
  assign stall_o          = (state_r == BUSY);

endmodule

// File: tb/tb_nerv_wb_bridge.sv
// Self-checking bench for nerv_wb_bridge with a transaction-level reference model.
module tb_nerv_wb_bridge;

  localparam int          TMO       = 8;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] TMO_RDATA = 32'h0000_0000;
  localparam int          NEVER     = 1000;
`ifdef WB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk_core = 1'b0;
  logic        rst_core = 1'b1;
  logic [31:0] imem_addr_i = 32'h0;
  logic [31:0] imem_data_o;
  logic        dmem_valid_i = 1'b0;
  logic [31:0] dmem_addr_i = 32'h0;
  logic [3:0]  dmem_wstrb_i = 4'h0;
  logic [31:0] dmem_wdata_i = 32'h0;
  logic [31:0] dmem_rdata_o;
  logic        stall_o;
  logic        core_cyc_o, core_stb_o, core_we_o;
  logic [3:0]  core_wstrb_o;
  logic [31:0] core_addr_o, core_data_o;
  logic [31:0] core_data_i = 32'h0;
  logic        core_ack_i = 1'b0;
  logic        data_mem_cyc_o, data_mem_stb_o, data_mem_we_o;
  logic [3:0]  data_mem_wstrb_o;
  logic [31:0] data_mem_addr_o, data_mem_data_o;
  logic [31:0] data_mem_data_i = 32'h0;
  logic        data_mem_ack_i = 1'b0;
  logic        err_o;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_imem = NOP;
  logic [31:0] exp_drd  = 32'h0;
  logic        exp_err  = 1'b0;

  always #5 clk_core = ~clk_core;

  nerv_wb_bridge #(
    .TIMEOUT_CYCLES (TMO),
    .RESET_INSTR    (NOP),
    .TIMEOUT_RDATA  (TMO_RDATA)
  ) dut (
    .clk_core         (clk_core),
    .rst_core         (rst_core),
    .imem_addr_i      (imem_addr_i),
    .imem_data_o      (imem_data_o),
    .dmem_valid_i     (dmem_valid_i),
    .dmem_addr_i      (dmem_addr_i),
    .dmem_wstrb_i     (dmem_wstrb_i),
    .dmem_wdata_i     (dmem_wdata_i),
    .dmem_rdata_o     (dmem_rdata_o),
    .stall_o          (stall_o),
    .core_cyc_o       (core_cyc_o),
    .core_stb_o       (core_stb_o),
    .core_we_o        (core_we_o),
    .core_wstrb_o     (core_wstrb_o),
    .core_addr_o      (core_addr_o),
    .core_data_o      (core_data_o),
    .core_data_i      (core_data_i),
    .core_ack_i       (core_ack_i),
    .data_mem_cyc_o   (data_mem_cyc_o),
    .data_mem_stb_o   (data_mem_stb_o),
    .data_mem_we_o    (data_mem_we_o),
    .data_mem_wstrb_o (data_mem_wstrb_o),
    .data_mem_addr_o  (data_mem_addr_o),
    .data_mem_data_o  (data_mem_data_o),
    .data_mem_data_i  (data_mem_data_i),
    .data_mem_ack_i   (data_mem_ack_i),
    .err_o            (err_o)
  );

  // One core request from an IDLE negedge until the bridge is IDLE again.
  // Delays are BUSY-cycle indices of each ack; rst_at >= 0 resets in that BUSY cycle.
  task automatic run_txn(input logic [31:0] iaddr, input logic valid,
                         input logic [31:0] daddr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input int idly, input int ddly,
                         input logic [31:0] ifd, input logic [31:0] drd,
                         input int rst_at, input string tag);
    int   k;
    int   nat;
    int   exp_len;
    logic we;
    logic timed;
    logic istb;
    logic dstb;
    we      = |wstrb;
    nat     = (valid && ddly > idly) ? ddly + 1 : idly + 1;
    timed   = 1'b0;
    exp_len = nat;
    if (rst_at >= 0) begin
      exp_len = rst_at + 1;
    end else if (TMO_EN && nat > TMO) begin
      exp_len = TMO;
      timed   = 1'b1;
    end

    rst_core        = 1'b0;
    imem_addr_i     = iaddr;
    dmem_valid_i    = valid;
    dmem_addr_i     = valid ? daddr : $urandom;
    dmem_wstrb_i    = wstrb;
    dmem_wdata_i    = wdata;
    core_ack_i      = 1'($urandom_range(0, 1));
    core_data_i     = $urandom;
    data_mem_ack_i  = 1'($urandom_range(0, 1));
    data_mem_data_i = $urandom;
    @(posedge clk_core);
    @(negedge clk_core);

    k = 0;
    while (stall_o === 1'b1 && k < 40) begin
      istb = (k <= idly);
      dstb = valid && (k <= ddly);
      n_checks++;
      if ({core_cyc_o, core_stb_o, data_mem_cyc_o, data_mem_stb_o} !== {istb, istb, dstb, dstb})
        $display("FAIL %s strobes busy_cycle=%0d got %b expected %b", tag, k,
                 {core_cyc_o, core_stb_o, data_mem_cyc_o, data_mem_stb_o}, {istb, istb, dstb, dstb});
      else n_pass++;
      n_checks++;
      if ({core_addr_o, core_we_o, core_wstrb_o, core_data_o} !== {iaddr, 1'b0, 4'h0, 32'h0})
        $display("FAIL %s fetch_req busy_cycle=%0d got addr %h we %b strb %h data %h expected addr %h and zero write fields",
                 tag, k, core_addr_o, core_we_o, core_wstrb_o, core_data_o, iaddr);
      else n_pass++;
      if (valid) begin
        n_checks++;
        if ({data_mem_addr_o, data_mem_we_o, data_mem_wstrb_o, data_mem_data_o} !== {daddr, we, wstrb, wdata})
          $display("FAIL %s data_req busy_cycle=%0d got %h/%b/%h/%h expected %h/%b/%h/%h", tag, k,
                   data_mem_addr_o, data_mem_we_o, data_mem_wstrb_o, data_mem_data_o, daddr, we, wstrb, wdata);
        else n_pass++;
      end
      imem_addr_i     = $urandom;
      dmem_valid_i    = 1'($urandom_range(0, 1));
      dmem_addr_i     = $urandom;
      dmem_wstrb_i    = 4'($urandom);
      dmem_wdata_i    = $urandom;
      core_ack_i      = (k == idly) ? 1'b1 : ((k > idly) ? 1'($urandom_range(0, 1)) : 1'b0);
      core_data_i     = (k == idly) ? ifd : $urandom;
      if (valid)
        data_mem_ack_i = (k == ddly) ? 1'b1 : ((k > ddly) ? 1'($urandom_range(0, 1)) : 1'b0);
      else
        data_mem_ack_i = 1'b1;
      data_mem_data_i = (valid && k == ddly) ? drd : $urandom;
      if (k == rst_at) rst_core = 1'b1;
      @(posedge clk_core);
      @(negedge clk_core);
      k++;
    end
    rst_core       = 1'b0;
    core_ack_i     = 1'b0;
    data_mem_ack_i = 1'b0;

    if (rst_at >= 0) begin
      exp_imem = NOP;
      exp_drd  = 32'h0;
      exp_err  = 1'b0;
    end else begin
      exp_imem = (timed && idly >= TMO) ? TMO_RDATA : ifd;
      if (valid && !we) exp_drd = (timed && ddly >= TMO) ? TMO_RDATA : drd;
      if (timed) exp_err = 1'b1;
    end

    n_checks++;
    if (k !== exp_len) $display("FAIL %s stall_len got %0d expected %0d", tag, k, exp_len);
    else n_pass++;
    n_checks++;
    if ({stall_o, core_stb_o, core_cyc_o, data_mem_stb_o, data_mem_cyc_o} !== 5'b0)
      $display("FAIL %s idle_ctrl got %b expected 00000", tag,
               {stall_o, core_stb_o, core_cyc_o, data_mem_stb_o, data_mem_cyc_o});
    else n_pass++;
    n_checks++;
    if (imem_data_o !== exp_imem) $display("FAIL %s imem_data got %h expected %h", tag, imem_data_o, exp_imem);
    else n_pass++;
    n_checks++;
    if (dmem_rdata_o !== exp_drd) $display("FAIL %s dmem_rdata got %h expected %h", tag, dmem_rdata_o, exp_drd);
    else n_pass++;
    n_checks++;
    if (err_o !== exp_err) $display("FAIL %s err got %b expected %b", tag, err_o, exp_err);
    else n_pass++;
    if (rst_at >= 0) begin
      n_checks++;
      if ({core_addr_o, data_mem_addr_o, data_mem_data_o, data_mem_wstrb_o, data_mem_we_o} !== 101'h0)
        $display("FAIL %s reset_bus got addr %h daddr %h ddata %h strb %h we %b expected all zero", tag,
                 core_addr_o, data_mem_addr_o, data_mem_data_o, data_mem_wstrb_o, data_mem_we_o);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_core = 1'b1;
    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    n_checks++;
    if ({stall_o, core_cyc_o, core_stb_o, core_we_o, data_mem_cyc_o, data_mem_stb_o, data_mem_we_o, err_o} !== 8'h0)
      $display("FAIL reset_ctrl got %b expected 00000000",
               {stall_o, core_cyc_o, core_stb_o, core_we_o, data_mem_cyc_o, data_mem_stb_o, data_mem_we_o, err_o});
    else n_pass++;
    n_checks++;
    if ({core_addr_o, core_data_o, core_wstrb_o, data_mem_addr_o, data_mem_data_o, data_mem_wstrb_o} !== 136'h0)
      $display("FAIL reset_bus got %h %h %h %h %h %h expected zeros", core_addr_o, core_data_o,
               core_wstrb_o, data_mem_addr_o, data_mem_data_o, data_mem_wstrb_o);
    else n_pass++;
    n_checks++;
    if ({imem_data_o, dmem_rdata_o} !== {NOP, 32'h0})
      $display("FAIL reset_rdata got %h/%h expected %h/00000000", imem_data_o, dmem_rdata_o, NOP);
    else n_pass++;
  endtask

  task automatic test_first_fetch();
    run_txn(32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0050_0093, 32'h0, -1, "first_fetch");
  endtask

  task automatic test_load();
    run_txn(32'h4, 1'b1, 32'h1000, 4'h0, 32'h0, 1, 4, 32'h0010_0113, $urandom, -1, "load");
  endtask

  task automatic test_store();
    run_txn(32'h8, 1'b1, 32'h2000, 4'b0011, 32'hCAFE_BABE, 1, 1, 32'h0020_0193, $urandom, -1, "store");
  endtask

  task automatic test_spurious();
    run_txn(32'hC, 1'b0, 32'h0, 4'h0, 32'h0, 3, 0, $urandom, 32'h0, -1, "spurious_ack");
  endtask

  task automatic test_reset_busy();
    run_txn(32'h10, 1'b1, 32'h3000, 4'h0, 32'h0, 6, 6, $urandom, $urandom, 2, "reset_busy");
  endtask

  task automatic test_timeout();
`ifdef WB_TIMEOUT_EN
    run_txn(32'h14, 1'b1, 32'h4000, 4'h0, 32'h0, 0, NEVER, $urandom, $urandom, -1, "timeout");
    run_txn(32'h18, 1'b1, 32'h4004, 4'h0, 32'h0, 1, 2, $urandom, $urandom, -1, "timeout_sticky");
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic valid;
      logic [3:0] wstrb;
      int idly;
      int ddly;
      valid = 1'($urandom_range(0, 1));
      wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      idly  = $urandom_range(0, 5);
      ddly  = $urandom_range(0, 5);
      if (TMO_EN && $urandom_range(0, 5) == 0) ddly = NEVER;
      run_txn($urandom, valid, $urandom, wstrb, $urandom, idly, ddly, $urandom, $urandom, -1, "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_load();
    test_store();
    test_spurious();
    test_reset_busy();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nerv_wb_bridge.md
Name: nerv_wb_bridge

Overview:
Bus adapter between the nerv core's native fixed-latency memory ports and the two Wishbone-style buses (instruction and data) of the processorci_top shell.
- Captures each fetch and data request and launches it on its bus.
- Holds the core stalled until every launched transaction is acknowledged.
- Returns registered read data.
- Replaces the current free-running, ack-ignoring connection with a correct ack-driven one.

Parameters:
TIMEOUT_CYCLES, 1024, ack wait limit per transaction; used only with WB_TIMEOUT_EN.
RESET_INSTR, 32'h0000_0013, value of imem_data_o after reset (NOP).
TIMEOUT_RDATA, 32'h0000_0000, read data returned on a timed-out channel.

Ports:
clk_core  in  1  core clock
rst_core  in  1  synchronous active-high reset
imem_addr_i  in  32  core fetch address
imem_data_o  out  32  registered instruction
dmem_valid_i  in  1  data request present
dmem_addr_i  in  32  data address
dmem_wstrb_i  in  4  byte strobes; 0 means read
dmem_wdata_i  in  32  write data
dmem_rdata_o  out  32  registered read data
stall_o  out  1  core stall
core_cyc_o, core_stb_o  out  1  instruction bus cycle/strobe
core_we_o  out  1  always 0
core_wstrb_o  out  4  always 0
core_addr_o  out  32  fetch address
core_data_o  out  32  always 0
core_data_i  in  32  fetch data
core_ack_i  in  1  fetch ack
data_mem_cyc_o, data_mem_stb_o, data_mem_we_o  out  1  data bus controls
data_mem_wstrb_o  out  4  strobes
data_mem_addr_o, data_mem_data_o  out  32  address and write data
data_mem_data_i  in  32  read data
data_mem_ack_i  in  1  data ack
err_o  out  1  sticky timeout flag

Behaviour:
Clocking and reset
- Single clock clk_core; rst_core is synchronous and active-high.
- Reset values:
  - state IDLE; stall_o=0.
  - all cyc/stb/we outputs 0; wstrb outputs 0; address/data outputs 0.
  - imem_data_o=RESET_INSTR; dmem_rdata_o=0; err_o=0.

IDLE state
- stall_o=0.
- The core consumes imem_data_o/dmem_rdata_o and presents its next request.
- On each IDLE edge (reset low):
  - latch imem_addr_i.
  - latch dmem_* if dmem_valid_i=1.
  - go to BUSY.
  - Fetch is always launched; data channel only if dmem_valid_i=1.

BUSY state
- stall_o=1.
- cyc/stb are high for each launched, not-yet-acked channel.
- Address, strobe and write data are held stable.
- data_mem_we_o = |wstrb.

Ack handling
- An ack counts only while that channel's stb is high. Ack in the first BUSY cycle is legal (zero-wait slave).
- On the ack edge:
  - set the channel's done bit and drop its cyc/stb.
  - capture core_data_i into imem_data_o.
  - capture data_mem_data_i into dmem_rdata_o for reads only; writes leave dmem_rdata_o unchanged.
- When all launched channels are done (same-cycle acks allowed), the next state is IDLE.

Latency and edge cases
- Minimum turnaround is 2 cycles per instruction (1 IDLE + 1 BUSY).
- Stall length equals the slowest ack.
- Ack while stb is low: ignored, no state change.
- Reset in BUSY: all strobes drop at that edge and the outstanding transaction is discarded.

Optional Feature:
WB_TIMEOUT_EN
- Defined:
  - A 16-bit wait counter clears on BUSY entry and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYCLES-1 with channels still outstanding:
    - force those channels done and return TIMEOUT_RDATA for them (for the fetch channel, imem_data_o=TIMEOUT_RDATA).
    - set err_o (sticky until reset).
    - return to IDLE next cycle.
- Undefined: no counter; BUSY waits indefinitely; err_o tied 0.

Decomposition:
- Package nerv_wb_bridge_pkg:
  - bridge_state_t enum {IDLE, BUSY}.
  - NOP_INSTR constant.
  - wb_req_t struct {addr, wdata, wstrb, we}.
- Sub-module nerv_wb_channel, instantiated twice (instruction, data):
  - holds the request register, stb/done bit and read-data latch.
  - inputs: launch, ack, rdata, force_done.
  - outputs: done, cyc/stb, rdata.
- The top holds the FSM, stall and timeout counter.

Test Plan:
- Reset, then release with imem_addr_i=0x0, slave acking in the first BUSY cycle with 0x00500093 -> stall_o high exactly 1 cycle; imem_data_o=0x00500093 in the following IDLE cycle.
- Load: dmem_valid_i=1, wstrb=0, addr 0x1000; fetch ack after 2 cycles, data ack after 5 -> stall_o high 5 cycles; dmem_rdata_o=data_mem_data_i at ack; core_stb_o drops after its ack while data_mem_stb_o stays high.
- Store: wstrb=4'b0011, wdata 0xCAFEBABE, both acks in the same cycle -> data_mem_we_o=1 with strobes and data stable throughout; back to IDLE next cycle; dmem_rdata_o unchanged.
- Spurious data_mem_ack_i pulses during IDLE and during a fetch-only BUSY -> no state or data change.
- rst_core asserted in the 3rd BUSY cycle -> next edge: all cyc/stb 0, stall_o 0, imem_data_o=0x00000013.
- With WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, data slave never acks -> return to IDLE after 8 BUSY cycles; err_o=1 and sticky; dmem_rdata_o=0.
